dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Slave end of the memory-stage dmem bus: word RAM plus a small MMIO block
// (cycle counter, timer compare/irq, console TX FIFO, fault status).
module dmem_responder #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic        dmem_read_en,
  input  logic        dmem_write_en,
  output logic [31:0] dmem_data_in,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        timer_irq,
  output logic        access_fault
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    R_CYC_LO, R_CYC_HI, R_TC_LO, R_TC_HI, R_TX, R_STATUS, R_FADDR, R_RSVD
  } reg_e;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [63:0]   cycle, timecmp;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] tx_cnt;
  logic          fault_st, ovf_st;
  logic [31:0]   fault_addr;

  // Decode
  logic [29:0] mmio_word;
  logic        in_ram, in_mmio, strobe, fault, rd_ok, wr_ok;
  reg_e        sel;
  assign mmio_word = dmem_addr[31:2] - MMIO_BASE[31:2];
  assign in_ram    = dmem_addr[31:2] < 30'(RAM_WORDS);
  assign in_mmio   = !in_ram && (mmio_word < 30'd8);
  assign sel       = reg_e'(mmio_word[2:0]);
  assign strobe    = rst_n && (dmem_read_en || dmem_write_en);
  assign fault     = strobe && ((dmem_addr[1:0] != 2'b00) ||
                                (dmem_read_en && dmem_write_en) ||
                                !(in_ram || in_mmio));
  assign rd_ok     = rst_n && dmem_read_en && !fault;
  assign wr_ok     = rst_n && dmem_write_en && !fault;

  logic ram_wr, tc_lo_wr, tc_hi_wr, status_wr, push, pop, do_push, full, empty;
  assign ram_wr    = wr_ok && in_ram;
  assign tc_lo_wr  = wr_ok && in_mmio && sel == R_TC_LO;
  assign tc_hi_wr  = wr_ok && in_mmio && sel == R_TC_HI;
  assign status_wr = wr_ok && in_mmio && sel == R_STATUS;
  assign push      = wr_ok && in_mmio && sel == R_TX;
  assign full      = tx_cnt == CW'(TX_DEPTH);
  assign empty     = tx_cnt == '0;
  assign pop       = !empty && console_ready;
  assign do_push   = push && !full;

  assign console_valid = !empty;
  assign console_data  = empty ? 8'd0 : tx_mem[rd_ptr];

  logic [31:0] status;
  assign status = {21'd0, ovf_st, fault_st, timer_irq, 4'(tx_cnt), 2'b00, empty, full};

  always_comb begin
    dmem_data_in = '0;
    if (rd_ok) begin
      if (in_ram) dmem_data_in = ram[dmem_addr[AW+1:2]];
      else begin
        case (sel)
          R_CYC_LO: dmem_data_in = cycle[31:0];
          R_CYC_HI: dmem_data_in = cycle[63:32];
          R_TC_LO:  dmem_data_in = timecmp[31:0];
          R_TC_HI:  dmem_data_in = timecmp[63:32];
          R_STATUS: dmem_data_in = status;
          R_FADDR:  dmem_data_in = fault_addr;
          default:  dmem_data_in = '0;
        endcase
      end
    end
  end

  // Storage arrays are not reset; write enables are already gated by rst_n.
  always_ff @(posedge clk) begin
    if (ram_wr)  ram[dmem_addr[AW+1:2]] <= dmem_data_out;
    if (do_push) tx_mem[wr_ptr]         <= dmem_data_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle        <= '0;
      timecmp      <= '1;
      timer_irq    <= 1'b0;
      access_fault <= 1'b0;
      fault_st     <= 1'b0;
      ovf_st       <= 1'b0;
      fault_addr   <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      tx_cnt       <= '0;
    end else begin
      cycle        <= cycle + 64'd1;
      timer_irq    <= cycle >= timecmp;
      access_fault <= fault;
      if (fault) begin
        fault_st   <= 1'b1;
        fault_addr <= dmem_addr;
      end else if (status_wr && dmem_data_out[9]) begin
        fault_st   <= 1'b0;
      end
      if (push && full)                        ovf_st <= 1'b1;
      else if (status_wr && dmem_data_out[10]) ovf_st <= 1'b0;
      if (tc_lo_wr) timecmp[31:0]  <= dmem_data_out;
      if (tc_hi_wr) timecmp[63:32] <= dmem_data_out;
      if (do_push)  wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      tx_cnt <= tx_cnt + CW'(do_push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a queue/array
// reference model of the bus, MMIO registers and console FIFO.
module tb_dmem_responder;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          RAMW  = 1024;
  localparam int          DEPTH = 8;

  logic        clk, rst_n;
  logic [31:0] dmem_addr, dmem_data_out, dmem_data_in;
  logic        dmem_read_en, dmem_write_en;
  logic        console_valid, console_ready, timer_irq, access_fault;
  logic [7:0]  console_data;

  dmem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_addr(dmem_addr), .dmem_data_out(dmem_data_out),
    .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en),
    .dmem_data_in(dmem_data_in),
    .console_valid(console_valid), .console_data(console_data),
    .console_ready(console_ready),
    .timer_irq(timer_irq), .access_fault(access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [63:0] m_cyc, m_tc;
  bit        m_irq, m_af, m_fault, m_ovf;
  bit [31:0] m_faddr;
  bit [7:0]  q[$];
  bit [31:0] m_ram [int];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] exp_status();
    return {21'd0, m_ovf, m_fault, m_irq, 4'(q.size()), 2'b00,
            q.size() == 0, q.size() == DEPTH};
  endfunction

  // One bus cycle: drive after negedge, check read data before the edge,
  // advance the model at the edge, check registered outputs after it.
  task automatic acc(input bit [31:0] a, input bit [31:0] wd,
                     input bit rd, input bit wr, input bit rdy);
    bit inr, inm, flt, known, full0;
    bit [31:0] exp, off;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_addr = a; dmem_data_out = wd;
    dmem_read_en = rd; dmem_write_en = wr; console_ready = rdy;
    #1;
    inr = a < RAMW * 4;
    inm = a >= BASE && a < BASE + 32;
    flt = (rd || wr) && (a[1:0] != 0 || (rd && wr) || !(inr || inm));
    off = a - BASE;
    known = 1'b1; exp = 0;
    if (rd && !flt) begin
      if (inr) begin
        if (m_ram.exists(int'(a >> 2))) exp = m_ram[int'(a >> 2)];
        else known = 1'b0;
      end else begin
        case (off)
          0:  exp = m_cyc[31:0];
          4:  exp = m_cyc[63:32];
          8:  exp = m_tc[31:0];
          12: exp = m_tc[63:32];
          20: exp = exp_status();
          24: exp = m_faddr;
          default: exp = 0;
        endcase
      end
    end
    if (known) chk("rdata", dmem_data_in, exp);
    @(posedge clk);
    full0 = q.size() == DEPTH;
    m_irq = m_cyc >= m_tc;
    m_af  = flt;
    if (flt) begin m_fault = 1; m_faddr = a; end
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (wr && !flt) begin
      if (inr) m_ram[int'(a >> 2)] = wd;
      else case (off)
        8:  m_tc[31:0]  = wd;
        12: m_tc[63:32] = wd;
        16: if (full0) m_ovf = 1; else q.push_back(wd[7:0]);
        20: begin if (wd[9]) m_fault = 0; if (wd[10]) m_ovf = 0; end
        default: ;
      endcase
    end
    m_cyc = m_cyc + 1;
    #1;
    chk("fault", access_fault, m_af);
    chk("irq", timer_irq, m_irq);
    chk("cvalid", console_valid, q.size() != 0);
    chk("cdata", console_data, q.size() != 0 ? q[0] : 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dmem_read_en = 1'b1; dmem_write_en = 1'b1; dmem_addr = 32'h41;
    console_ready = 1'b1;
    @(posedge clk);
    m_cyc = 0; m_tc = '1; m_irq = 0; m_af = 0; m_fault = 0; m_ovf = 0;
    m_faddr = 0; q.delete();
    #1;
    chk("rst_fault", access_fault, 1'b0);
    chk("rst_irq", timer_irq, 1'b0);
    chk("rst_cvalid", console_valid, 1'b0);
    chk("rst_cdata", console_data, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; dmem_addr = 0; dmem_data_out = 0;
    dmem_read_en = 0; dmem_write_en = 0; console_ready = 0;
    do_reset();
    acc(BASE + 32'h14, 0, 1, 0, 0);        // STATUS: only empty set
    acc(BASE + 32'h00, 0, 1, 0, 0);
    // RAM write then read-after-write
    acc(32'h40, 32'hDEAD_BEEF, 0, 1, 0);
    acc(32'h40, 0, 1, 0, 0);
    // Misaligned read, fault logging, write-1-to-clear
    acc(32'h41, 0, 1, 0, 0);
    acc(BASE + 32'h14, 0, 1, 0, 0);
    acc(BASE + 32'h18, 0, 1, 0, 0);
    acc(BASE + 32'h14, 32'h200, 0, 1, 0);
    acc(BASE + 32'h14, 0, 1, 0, 0);
    // Conflict, unmapped and range edges
    acc(32'h40, 32'h1, 1, 1, 0);
    acc(32'h40, 0, 1, 0, 0);
    acc(32'h2000_0000, 0, 1, 0, 0);
    acc(32'hFFC, 32'h1234_5678, 0, 1, 0);
    acc(32'hFFC, 0, 1, 0, 0);
    acc(32'h1000, 0, 1, 0, 0);
    acc(BASE + 32'h20, 0, 1, 0, 0);
    acc(BASE + 32'h1C, 32'hFFFF_FFFF, 0, 1, 0);
    acc(BASE + 32'h1C, 0, 1, 0, 0);
    acc(BASE + 32'h00, 32'h55, 0, 1, 0);
    acc(BASE + 32'h18, 0, 1, 0, 0);
    // Timer
    do_reset();
    acc(BASE + 32'h0C, 0, 0, 1, 0);
    acc(BASE + 32'h08, 20, 0, 1, 0);
    for (int i = 0; i < 25; i++) acc(0, 0, 0, 0, 0);
    acc(BASE + 32'h14, 0, 1, 0, 0);
    acc(BASE + 32'h08, 32'hFFFF_FFFF, 0, 1, 0);
    acc(BASE + 32'h0C, 32'hFFFF_FFFF, 0, 1, 0);
    for (int i = 0; i < 3; i++) acc(0, 0, 0, 0, 0);
    // FIFO overflow and drain
    for (int i = 0; i < 9; i++) acc(BASE + 32'h10, 32'h41 + i, 0, 1, 0);
    acc(BASE + 32'h14, 0, 1, 0, 0);
    acc(BASE + 32'h10, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) acc(0, 0, 0, 0, 1);
    acc(BASE + 32'h14, 32'h400, 0, 1, 0);
    acc(BASE + 32'h14, 0, 1, 0, 0);
    // Reset mid-operation
    for (int i = 0; i < 3; i++) acc(BASE + 32'h10, 32'h60 + i, 0, 1, 0);
    for (int i = 0; i < 1000 && m_cyc < 100; i++) acc(0, 0, 0, 0, 0);
    chk("cyc100", m_cyc, 64'd100);
    do_reset();
    acc(BASE + 32'h00, 0, 1, 0, 0);
    acc(BASE + 32'h14, 0, 1, 0, 0);
    acc(32'h40, 0, 1, 0, 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit [31:0] a;
      bit rd, wr;
      int k, op;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: a = {$urandom_range(0, 15), 2'b00};
        3:       a = 32'hFFC;
        4, 5, 6: a = BASE + 32'($urandom_range(0, 7) * 4);
        7:       a = 32'h40 + 32'($urandom_range(1, 3));
        8:       a = BASE + 32'h20;
        default: a = 32'h1000;
      endcase
      op = $urandom_range(0, 9);
      rd = (op inside {[1:4]}) || op == 9;
      wr = (op inside {[5:8]}) || op == 9;
      acc(a, $urandom, rd, wr, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
